// File: rtl/log2_pkg.sv
// rtl/log2_pkg.sv - shared width defaults, result-width helper and FSM encoding for the floor-log2 unit
package log2_pkg;

  localparam int W_DEFAULT = 128;

  function automatic int lw_of(input int w);
    return $clog2(w);
  endfunction

  localparam int LW_DEFAULT = lw_of(W_DEFAULT);

  typedef logic [LW_DEFAULT-1:0] log_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/log2_step.sv
// rtl/log2_step.sv - one combinational binary-search step: shift V right by 2**step if anything survives
module log2_step
  import log2_pkg::*;
#(
  parameter int W  = W_DEFAULT,
  parameter int LW = lw_of(W)
) (
  input  logic [W-1:0]  i_v,
  input  logic [LW-1:0] i_step,
  output logic [W-1:0]  o_v,
  output logic [LW-1:0] o_bit
);

  logic [LW-1:0] w_s;
  logic [W-1:0]  w_shifted;

  always_comb begin
    w_s       = LW'(1) << i_step;
    w_shifted = i_v >> w_s;
    if (|w_shifted) begin
      o_v   = w_shifted;
      o_bit = w_s;
    end else begin
      o_v   = i_v;
      o_bit = '0;
    end
  end

endmodule

// File: rtl/log2_seq.sv
// rtl/log2_seq.sv - iterative floor-log2 with zero/exact flags, fixed LW-cycle latency
// Optional LOG2_SEQ_CEIL_EN adds the o_log_ceil output.
module log2_seq
  import log2_pkg::*;
#(
  parameter int W  = W_DEFAULT,
  parameter int LW = lw_of(W)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  input  logic [W-1:0]  i_din,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic [LW-1:0] o_log,
  output logic          o_zero,
  output logic          o_exact
`ifdef LOG2_SEQ_CEIL_EN
  ,
  output logic [LW:0]   o_log_ceil
`endif
);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [W-1:0]  r_v;
  logic [LW-1:0] r_r;
  logic [LW-1:0] r_step;
  logic          r_zero;
  logic          r_exact;
  logic [W-1:0]  w_next_v;
  logic [LW-1:0] w_bit;

  log2_step #(.W(W), .LW(LW)) u_step (
    .i_v    (r_v),
    .i_step (r_step),
    .o_v    (w_next_v),
    .o_bit  (w_bit)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (i_in_valid) w_state_nxt = ST_SCAN;
      ST_SCAN: if (r_step == '0) w_state_nxt = ST_DONE;
      ST_DONE: if (i_out_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_in_ready  = (r_state == ST_IDLE);
    o_out_valid = (r_state == ST_DONE);
    o_log       = r_r;
    o_zero      = r_zero;
    o_exact     = r_exact;
  end

`ifdef LOG2_SEQ_CEIL_EN
  logic [LW:0]   r_log_ceil;
  logic [LW-1:0] w_final_r;
  logic [LW:0]   w_ceil;

  // Ceil is derived from the final R during the last SCAN edge so it lands with OUT_VALID.
  always_comb begin
    w_final_r = r_r | w_bit;
    w_ceil    = r_zero ? '0 : ({1'b0, w_final_r} + (r_exact ? (LW+1)'(0) : (LW+1)'(1)));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                                r_log_ceil <= '0;
    else if (r_state == ST_SCAN && r_step == '0) r_log_ceil <= w_ceil;
  end

  assign o_log_ceil = r_log_ceil;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_v     <= '0;
      r_r     <= '0;
      r_step  <= '0;
      r_zero  <= 1'b0;
      r_exact <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_in_valid) begin
            r_v     <= i_din;
            r_r     <= '0;
            r_step  <= LW'(LW - 1);
            r_zero  <= (i_din == '0);
            // DIN-1 wraps to all-ones for zero; the nonzero term masks that case.
            r_exact <= (i_din != '0) && ((i_din & (i_din - W'(1))) == '0);
          end
        end
        ST_SCAN: begin
          r_v <= w_next_v;
          r_r <= r_r | w_bit;
          if (r_step != '0) r_step <= r_step - LW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_log2_seq.sv
// tb/tb_log2_seq.sv - directed self-checking bench for log2_seq (W=128)
module tb_log2_seq;

  localparam int W  = 128;
  localparam int LW = 7;

  logic          clk;
  logic          rst_n;
  logic          i_in_valid;
  logic          o_in_ready;
  logic [W-1:0]  i_din;
  logic          o_out_valid;
  logic          i_out_ready;
  logic [LW-1:0] o_log;
  logic          o_zero;
  logic          o_exact;
`ifdef LOG2_SEQ_CEIL_EN
  logic [LW:0]   o_log_ceil;
`endif

  int n_tests;
  int n_fail;
  int cyc;

  log2_seq #(.W(W)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_din       (i_din),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_log       (o_log),
    .o_zero      (o_zero),
    .o_exact     (o_exact)
`ifdef LOG2_SEQ_CEIL_EN
    ,
    .o_log_ceil  (o_log_ceil)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepts one operand, waits (bounded) for OUT_VALID, captures results and takes them.
  task automatic run_op(input logic [W-1:0] din, output logic [LW-1:0] lg, output logic zr,
                        output logic ex, output logic [LW:0] lc, output int lat,
                        output int rdy_bad);
    int guard;
    guard = 0;
    while (!o_in_ready && guard < 50) begin
      tick();
      guard++;
    end
    i_in_valid = 1'b1;
    i_din      = din;
    tick();
    i_in_valid = 1'b0;
    lat        = 0;
    rdy_bad    = 0;
    while (!o_out_valid && lat < 50) begin
      if (o_in_ready) rdy_bad++;
      tick();
      lat++;
    end
    if (o_in_ready) rdy_bad++;
    lg = o_log;
    zr = o_zero;
    ex = o_exact;
`ifdef LOG2_SEQ_CEIL_EN
    lc = o_log_ceil;
`else
    lc = '0;
`endif
    i_out_ready = 1'b1;
    tick();
    i_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    i_in_valid  = 1'b0;
    i_out_ready = 1'b0;
    i_din       = '0;
    repeat (3) tick();
    n_tests++;
    if ({o_in_ready, o_out_valid, o_log, o_zero, o_exact} !== {1'b1, 1'b0, 7'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b vld=%b log=%0d z=%b e=%b, want rdy=1 vld=0 log=0 z=0 e=0",
               o_in_ready, o_out_valid, o_log, o_zero, o_exact);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [LW-1:0] lg; logic zr, ex; logic [LW:0] lc; int lat, rb;
    run_op(128'd1, lg, zr, ex, lc, lat, rb);
    n_tests++;
    if (lat !== 7) begin n_fail++; $display("FAIL one_latency: got %0d want 7", lat); end
    n_tests++;
    if ({lg, zr, ex} !== {7'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL one_result: got log=%0d z=%b e=%b want log=0 z=0 e=1", lg, zr, ex);
    end
    n_tests++;
    if (rb !== 0) begin n_fail++; $display("FAIL one_ready_busy: in_ready high %0d busy cycles, want 0", rb); end
  endtask

  task automatic test_pow2_sweep();
    logic [W-1:0] one;
    int guard, acc, prev;
    one         = 128'd1;
    prev        = -1;
    i_out_ready = 1'b1;
    i_in_valid  = 1'b1;
    i_din       = one;
    for (int k = 0; k < W; k++) begin
      guard = 0;
      while (!o_in_ready && guard < 50) begin tick(); guard++; end
      acc = cyc;
      tick();
      i_din = one << ((k + 1) % W);
      if (prev >= 0) begin
        n_tests++;
        if (acc - prev !== 9) begin
          n_fail++;
          $display("FAIL sweep_spacing k=%0d: got %0d want 9", k, acc - prev);
        end
      end
      prev  = acc;
      guard = 0;
      while (!o_out_valid && guard < 50) begin tick(); guard++; end
      n_tests++;
      if ({o_log, o_exact, o_zero} !== {LW'(k), 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL sweep_pow2 k=%0d: got log=%0d e=%b z=%b want log=%0d e=1 z=0",
                 k, o_log, o_exact, o_zero, k);
      end
    end
    i_in_valid = 1'b0;
    tick();
    i_out_ready = 1'b0;
    tick();
  endtask

  task automatic test_special();
    logic [LW-1:0] lg; logic zr, ex; logic [LW:0] lc; int lat, rb;
    run_op(128'd0, lg, zr, ex, lc, lat, rb);
    n_tests++;
    if (lat !== 7) begin n_fail++; $display("FAIL zero_latency: got %0d want 7", lat); end
    n_tests++;
    if ({lg, zr, ex} !== {7'd0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL zero_result: got log=%0d z=%b e=%b want log=0 z=1 e=0", lg, zr, ex);
    end
    run_op({W{1'b1}}, lg, zr, ex, lc, lat, rb);
    n_tests++;
    if ({lg, zr, ex} !== {7'd127, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL ones_result: got log=%0d z=%b e=%b want log=127 z=0 e=0", lg, zr, ex);
    end
    run_op(128'h6, lg, zr, ex, lc, lat, rb);
    n_tests++;
    if ({lg, zr, ex} !== {7'd2, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL six_result: got log=%0d z=%b e=%b want log=2 z=0 e=0", lg, zr, ex);
    end
  endtask

  task automatic test_backpressure();
    int guard, bad;
    guard = 0;
    while (!o_in_ready && guard < 50) begin tick(); guard++; end
    i_in_valid = 1'b1;
    i_din      = 128'h6;
    tick();
    guard = 0;
    while (!o_out_valid && guard < 50) begin
      i_din = i_din ^ 128'h5a5;
      tick();
      guard++;
    end
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      i_din = {4{$urandom}};
      tick();
      if ({o_out_valid, o_in_ready, o_log, o_zero, o_exact} !== {1'b1, 1'b0, 7'd2, 1'b0, 1'b0}) bad++;
    end
    n_tests++;
    if (bad !== 0) begin n_fail++; $display("FAIL bp_hold: got %0d unstable cycles want 0", bad); end
    i_out_ready = 1'b1;
    tick();
    i_in_valid  = 1'b0;
    i_out_ready = 1'b0;
    n_tests++;
    if ({o_in_ready, o_out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL bp_release: got rdy=%b vld=%b want rdy=1 vld=0", o_in_ready, o_out_valid);
    end
    tick();
  endtask

  task automatic test_reset_abort();
    int guard, spur;
    guard = 0;
    while (!o_in_ready && guard < 50) begin tick(); guard++; end
    i_in_valid = 1'b1;
    i_din      = 128'h80;
    tick();
    i_in_valid = 1'b0;
    repeat (3) tick();
    n_tests++;
    if (o_exact !== 1'b1) begin n_fail++; $display("FAIL abort_pre_exact: got %b want 1", o_exact); end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({o_in_ready, o_out_valid, o_log, o_zero, o_exact} !== {1'b1, 1'b0, 7'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL abort_async: got rdy=%b vld=%b log=%0d z=%b e=%b want rdy=1 vld=0 log=0 z=0 e=0",
               o_in_ready, o_out_valid, o_log, o_zero, o_exact);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    spur  = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1) spur++;
    end
    n_tests++;
    if (spur !== 0) begin n_fail++; $display("FAIL abort_release: got %0d bad cycles want 0", spur); end
  endtask

`ifdef LOG2_SEQ_CEIL_EN
  task automatic test_ceil();
    logic [LW-1:0] lg; logic zr, ex; logic [LW:0] lc; int lat, rb;
    logic [W-1:0] big;
    run_op(128'd5, lg, zr, ex, lc, lat, rb);
    n_tests++;
    if ({lg, lc} !== {7'd2, 8'd3}) begin
      n_fail++; $display("FAIL ceil_5: got log=%0d ceil=%0d want 2 3", lg, lc);
    end
    run_op(128'd64, lg, zr, ex, lc, lat, rb);
    n_tests++;
    if ({lg, lc} !== {7'd6, 8'd6}) begin
      n_fail++; $display("FAIL ceil_64: got log=%0d ceil=%0d want 6 6", lg, lc);
    end
    big = {1'b1, 126'd0, 1'b1};
    run_op(big, lg, zr, ex, lc, lat, rb);
    n_tests++;
    if ({lg, lc} !== {7'd127, 8'd128}) begin
      n_fail++; $display("FAIL ceil_big: got log=%0d ceil=%0d want 127 128", lg, lc);
    end
    run_op(128'd0, lg, zr, ex, lc, lat, rb);
    n_tests++;
    if (lc !== 8'd0) begin n_fail++; $display("FAIL ceil_zero: got %0d want 0", lc); end
  endtask
`endif

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    test_reset();
    test_single();
    test_pow2_sweep();
    test_special();
    test_backpressure();
    test_reset_abort();
`ifdef LOG2_SEQ_CEIL_EN
    test_ceil();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/log2_seq.md
Name: log2_seq

Overview:
- Iterative floor-log2 unit; the inverse of the combinational power-of-two generator.
- Accepts an unsigned word and returns the bit index of its most-significant set bit.
- Also returns zero and exact-power-of-two flags.
- Binary search, one halving step per clock, fixed latency; sits behind valid/ready handshakes in arithmetic datapaths that need exponent extraction.

Parameters:
- W, 128, input data width; power of two, 2..1024.
- LW, $clog2(W) (7), result width; derived, do not override.

Ports:
- CLK  input  1  rising-edge clock
- RST_N  input  1  asynchronous active-low reset
- IN_VALID  input  1  DIN valid
- IN_READY  output  1  unit can accept DIN
- DIN  input  W  unsigned operand
- OUT_VALID  output  1  result valid, held until taken
- OUT_READY  input  1  consumer takes result
- LOG  output  LW  floor(log2(DIN)); 0 when DIN==0
- ZERO  output  1  DIN was 0
- EXACT  output  1  DIN had exactly one bit set

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset: state IDLE, IN_READY=1, OUT_VALID=0, LOG=0, ZERO=0, EXACT=0, internal V=0, step=0.
- FSM states:
  - IDLE: IN_READY=1. On IN_VALID&IN_READY:
    - V<=DIN, R<=0, step<=LW-1
    - ZERO<=(DIN==0)
    - EXACT<=(DIN!=0)&&((DIN&(DIN-1))==0)
    - goto SCAN
  - SCAN: IN_READY=0. Each edge:
    - s=2**step
    - if (V>>s)!=0 then V<=V>>s and R<=R|s
    - if step==0 goto DONE, else step<=step-1
  - DONE: OUT_VALID=1; LOG=R. On OUT_READY goto IDLE.
- Output hold: LOG/ZERO/EXACT stable from entry to DONE until handshake; DIN changes ignored outside IDLE.
- Latency: OUT_VALID first high exactly LW cycles after the accept cycle, data-independent, including DIN==0.
- Throughput: IDLE is entered the cycle after the output handshake; no same-cycle accept in DONE. Peak rate is one op per LW+2 cycles.
- Width rules:
  - DIN-1 computed at W bits (wraps to all-ones for 0; guarded by the DIN!=0 term).
  - R is LW bits; max result W-1 fits.
- Boundaries:
  - DIN=1 gives LOG=0, EXACT=1, ZERO=0.
  - DIN=0 gives LOG=0, ZERO=1, EXACT=0.
  - DIN=all-ones gives LOG=W-1, EXACT=0.
- OUT_READY held high before DONE has no effect. IN_VALID outside IDLE is ignored (not queued).
- RST_N low mid-SCAN or mid-DONE: immediate abort, all outputs to reset values; no result emitted after release.

Optional Feature:
- Macro: LOG2_SEQ_CEIL_EN
- Defined:
  - Adds output LOG_CEIL, width LW+1, valid with OUT_VALID.
  - LOG_CEIL = LOG + (EXACT ? 0 : 1) for DIN!=0; 0 for DIN==0.
  - Example: DIN=2**(W-1)+1 gives W.
  - Registered at DONE entry; no latency change.
- Undefined: port absent, no extra logic; all other behaviour identical.

Decomposition:
- Package log2_pkg:
  - default W
  - LW derivation function
  - FSM state enum (IDLE, SCAN, DONE; 2-bit encoding)
  - shared typedef for result width
- Sub-module log2_step: combinational single binary-search step.
  - Inputs: V, step.
  - Outputs: next V and the bit to OR into R.
  - Instantiated once inside log2_seq; reusable by a future fully-unrolled pipelined variant.

Test Plan (W=128, LW=7):
- Reset then DIN=1 with IN_VALID for one cycle → OUT_VALID 7 cycles later, LOG=0, ZERO=0, EXACT=1; IN_READY=0 throughout SCAN/DONE.
- Sweep DIN=2**k for k=0..127, OUT_READY always 1 → LOG=k, EXACT=1 each time; spacing between accepts is 9 cycles.
- DIN=0 → LOG=0, ZERO=1, EXACT=0, latency still 7. DIN=all-ones → LOG=127, EXACT=0. DIN=0x6 → LOG=2, EXACT=0.
- Backpressure: OUT_READY=0 for 20 cycles after DONE, with DIN toggled and IN_VALID=1 meanwhile → LOG/flags stable, no second accept; raising OUT_READY gives IN_READY=1 next cycle.
- Deassert RST_N at step 3 of SCAN with DIN=0x80 → outputs zero asynchronously; after release IDLE, IN_READY=1, no spurious OUT_VALID.
- With LOG2_SEQ_CEIL_EN: DIN=5 → LOG=2, LOG_CEIL=3; DIN=64 → LOG=6, LOG_CEIL=6; DIN=2**127+1 → LOG_CEIL=128.
